// File: rtl/freq_meas_pkg.sv
// Shared types and constants for the pulse-train period/high-time meter.
package freq_meas_pkg;

    localparam int CNT_W_DEF = 24;
    localparam logic [CNT_W_DEF-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } meas_state_e;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous level plus rise/fall detection.
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic sig_in,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   dly;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_ff <= '0;
            dly     <= 1'b0;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], sig_in};
            dly     <= sync_ff[SYNC_STAGES-1];
        end
    end

    assign sync = sync_ff[SYNC_STAGES-1];
    assign rise = sync & ~dly;
    assign fall = ~sync & dly;

endmodule

// File: rtl/freq_period_meter.sv
// Measures period and high time of a slow pulse train in clock cycles and
// flags lock once consecutive periods agree.
//
// state   | meaning
// IDLE    | disabled, counters held at zero
// ARM     | waiting for the first rising edge of a fresh measurement
// MEASURE | counting a period; each rising edge reports and restarts
module freq_period_meter
    import freq_meas_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_COUNT  = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             timeout,
    output logic             locked
);

    localparam logic [CNT_W-1:0] CNT_TOP   = '1;
    localparam int               MATCH_W   = $clog2(LOCK_COUNT);
    localparam logic [MATCH_W-1:0] MATCH_TOP = MATCH_W'(LOCK_COUNT - 1);

    meas_state_e        state, state_nxt;
    logic [CNT_W-1:0]   cnt, hcnt, hold_high;
    logic               fall_seen;
    logic [MATCH_W-1:0] match_cnt, match_nxt;
    logic               prev_valid, period_match;
    logic               start, do_meas, do_to;
    logic               sync, rise, fall;

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clock (clock),
        .reset (reset),
        .sig_in(sig_in),
        .sync  (sync),
        .rise  (rise),
        .fall  (fall)
    );

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        do_meas   = 1'b0;
        do_to     = 1'b0;
        case (state)
            IDLE: begin
                if (enable) state_nxt = ARM;
            end
            ARM: begin
                if (!enable) begin
                    state_nxt = IDLE;
                end else if (rise) begin
                    start     = 1'b1;
                    state_nxt = MEASURE;
                end else if (cnt == CNT_TOP) begin
                    do_to = 1'b1;
                end
            end
            MEASURE: begin
                // a rise in the same cycle as the terminal count still counts
                if (!enable) begin
                    state_nxt = IDLE;
                end else if (rise) begin
                    do_meas = 1'b1;
                end else if (cnt == CNT_TOP) begin
                    do_to     = 1'b1;
                    state_nxt = ARM;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        period_match = prev_valid && (cnt == period);
        match_nxt    = '0;
        if (period_match) begin
            match_nxt = (match_cnt == MATCH_TOP) ? match_cnt : match_cnt + MATCH_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            hcnt       <= '0;
            hold_high  <= '0;
            fall_seen  <= 1'b0;
            match_cnt  <= '0;
            prev_valid <= 1'b0;
            period     <= '0;
            high_time  <= '0;
            meas_valid <= 1'b0;
            timeout    <= 1'b0;
            locked     <= 1'b0;
        end else begin
            state      <= state_nxt;
            meas_valid <= do_meas;
            timeout    <= do_to;
            if (!enable || state == IDLE) begin
                cnt       <= '0;
                hcnt      <= '0;
                fall_seen <= 1'b0;
                if (!enable) begin
                    locked     <= 1'b0;
                    match_cnt  <= '0;
                    prev_valid <= 1'b0;
                end
            end else if (start || do_meas) begin
                cnt       <= CNT_W'(1);
                hcnt      <= CNT_W'(1);
                fall_seen <= 1'b0;
                if (do_meas) begin
                    period     <= cnt;
                    high_time  <= hold_high;
                    prev_valid <= 1'b1;
                    match_cnt  <= match_nxt;
                    locked     <= (match_nxt == MATCH_TOP);
                end
            end else if (do_to) begin
                cnt        <= '0;
                hcnt       <= '0;
                fall_seen  <= 1'b0;
                locked     <= 1'b0;
                match_cnt  <= '0;
                prev_valid <= 1'b0;
            end else begin
                cnt <= (cnt == CNT_TOP) ? cnt : cnt + CNT_W'(1);
                if (state == MEASURE) begin
                    if (sync && !fall_seen && hcnt != CNT_TOP) hcnt <= hcnt + CNT_W'(1);
                    if (fall && !fall_seen) begin
                        hold_high <= hcnt;
                        fall_seen <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_freq_period_meter.sv
// Self-checking bench: timestamp-based reference model plus directed and random pulse trains.
module tb_freq_period_meter;

    localparam int CW   = 8;
    localparam int SS   = 2;
    localparam int LC   = 2;
    localparam int CMAX = (1 << CW) - 1;
    localparam int HIST = 131072;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic          sig_in = 1'b0;
    logic [CW-1:0] period, high_time;
    logic          meas_valid, timeout, locked;

    freq_period_meter #(.CNT_W(CW), .SYNC_STAGES(SS), .LOCK_COUNT(LC)) dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .sig_in    (sig_in),
        .period    (period),
        .high_time (high_time),
        .meas_valid(meas_valid),
        .timeout   (timeout),
        .locked    (locked)
    );

    always #5 clock = ~clock;

    typedef struct {
        int p;
        int h;
        int l;
        int at;
    } rec_t;

    int   n_pass = 0;
    int   n_total = 0;
    int   cyc = 0;
    bit   hist[0:HIST-1];
    rec_t strobes[$];
    rec_t touts[$];
    int   rise_drv[$];
    int   last_mv_at = 0;

    // reference model state: timestamps of synchronized edges rather than counters
    bit model_on = 0;
    int mode = 0;          // 0 idle, 1 armed, 2 measuring
    int t_rise, t_fall, arm_since;
    bit fall_seen_m, have_prev;
    int match_m;
    int e_period = 0, e_high = 0;
    bit e_mv = 0, e_to = 0, e_lock = 0;

    function automatic bit hs(input int i);
        return (i < 1) ? 1'b0 : hist[i];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0d required=%0d (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic drop_lock();
        e_lock    = 0;
        have_prev = 0;
        match_m   = 0;
    endtask

    always @(posedge clock) begin : ref_model
        bit r, f;
        int np;
        cyc = cyc + 1;
        hist[cyc] = sig_in;
        e_mv = 0;
        e_to = 0;
        if (reset) begin
            model_on = 1;
            mode = 0;
            e_period = 0;
            e_high = 0;
            fall_seen_m = 0;
            drop_lock();
            hist[cyc] = 0;
            hist[cyc-1] = 0;
            if (cyc >= 2) hist[cyc-2] = 0;
        end else if (model_on) begin
            // synchronized level seen by the decision at this edge lags sig_in by SS samples
            r = hs(cyc - SS) && !hs(cyc - SS - 1);
            f = !hs(cyc - SS) && hs(cyc - SS - 1);
            if (mode == 0) begin
                if (enable) begin
                    mode = 1;
                    arm_since = cyc;
                end
            end else if (!enable) begin
                mode = 0;
                drop_lock();
            end else if (mode == 1) begin
                if (r) begin
                    mode = 2;
                    t_rise = cyc;
                    fall_seen_m = 0;
                end else if (cyc - arm_since == CMAX + 1) begin
                    e_to = 1;
                    arm_since = cyc;
                    drop_lock();
                end
            end else begin
                if (r) begin
                    np = cyc - t_rise;
                    if (have_prev && np == e_period) match_m = (match_m < LC - 1) ? match_m + 1 : match_m;
                    else match_m = 0;
                    e_lock = (match_m == LC - 1);
                    e_period = np;
                    e_high = t_fall - t_rise;
                    have_prev = 1;
                    e_mv = 1;
                    t_rise = cyc;
                    fall_seen_m = 0;
                end else begin
                    if (f && !fall_seen_m) begin
                        t_fall = cyc;
                        fall_seen_m = 1;
                    end
                    if (cyc - t_rise == CMAX) begin
                        e_to = 1;
                        mode = 1;
                        arm_since = cyc;
                        drop_lock();
                    end
                end
            end
        end
    end

    always @(negedge clock) begin : compare
        if (model_on) begin
            chk("period", period, e_period);
            chk("high_time", high_time, e_high);
            chk("meas_valid", meas_valid, e_mv);
            chk("timeout", timeout, e_to);
            chk("locked", locked, e_lock);
        end
        if (meas_valid === 1'b1) begin
            strobes.push_back('{p: int'(period), h: int'(high_time), l: int'(locked), at: cyc});
            last_mv_at = cyc;
        end
        if (timeout === 1'b1)
            touts.push_back('{p: int'(period), h: int'(high_time), l: int'(locked), at: cyc});
    end

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic wave(input int p, input int h, input int n);
        for (int k = 0; k < n; k++) begin
            rise_drv.push_back(cyc);
            sig_in = 1'b1;
            repeat (h) tick();
            sig_in = 1'b0;
            repeat (p - h) tick();
        end
    endtask

    task automatic hold_low(input int n);
        sig_in = 1'b0;
        repeat (n) tick();
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog time limit reached at cycle %0d", cyc);
        $fatal(1, "time limit");
    end

    initial begin : stim
        int lm, p, h;
        reset = 1'b1;
        enable = 1'b0;
        sig_in = 1'b0;
        repeat (3) tick();
        chk("rst_period", period, 0);
        chk("rst_locked", locked, 0);
        chk("rst_valid", meas_valid, 0);
        reset = 1'b0;
        enable = 1'b1;
        hold_low(5);

        // square wave, 20 period / 10 high
        strobes.delete();
        rise_drv.delete();
        wave(20, 10, 4);
        chk("t1_count", strobes.size(), 3);
        chk("t1_period", strobes[0].p, 20);
        chk("t1_high", strobes[0].h, 10);
        chk("t1_lock0", strobes[0].l, 0);
        chk("t1_lock1", strobes[1].l, 1);
        chk("t1_latency", strobes[0].at, rise_drv[1] + 3);

        // 10/3, then switch to 32/16
        strobes.delete();
        wave(10, 3, 4);
        chk("t2_mismatch_lock", strobes[1].l, 0);
        chk("t2_period", strobes[2].p, 10);
        chk("t2_high", strobes[2].h, 3);
        chk("t2_lock", strobes[2].l, 1);
        strobes.delete();
        wave(32, 16, 4);
        chk("t2b_first_p", strobes[1].p, 32);
        chk("t2b_first_l", strobes[1].l, 0);
        chk("t2b_next_l", strobes[2].l, 1);
        chk("t2b_high", strobes[2].h, 16);

        // held low: timeout 255 cycles after the last strobe
        lm = last_mv_at;
        touts.delete();
        strobes.delete();
        hold_low(300);
        chk("t3_to_count", touts.size(), 1);
        chk("t3_to_delay", touts[0].at - lm, 255);
        chk("t3_to_period", touts[0].p, 32);
        chk("t3_to_lock", touts[0].l, 0);
        wave(20, 10, 3);
        chk("t3_re_count", strobes.size(), 2);
        chk("t3_re_period", strobes[0].p, 20);
        chk("t3_re_lock", strobes[0].l, 0);

        // enable dropped mid-period
        sig_in = 1'b1;
        repeat (5) tick();
        enable = 1'b0;
        tick();
        chk("t4_lock_off", locked, 0);
        strobes.delete();
        repeat (3) tick();
        enable = 1'b1;
        tick();
        sig_in = 1'b0;
        repeat (10) tick();
        rise_drv.delete();
        wave(20, 10, 3);
        chk("t4_count", strobes.size(), 2);
        chk("t4_period", strobes[0].p, 20);
        chk("t4_lock", strobes[0].l, 0);
        chk("t4_latency", strobes[0].at, rise_drv[1] + 3);

        // reset pulse mid-measure
        wave(20, 10, 2);
        sig_in = 1'b1;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t5_period", period, 0);
        chk("t5_high", high_time, 0);
        chk("t5_lock", locked, 0);
        repeat (6) tick();
        sig_in = 1'b0;
        repeat (10) tick();
        strobes.delete();
        wave(20, 10, 4);
        chk("t5_re_period", strobes[$].p, 20);
        chk("t5_re_lock", strobes[$].l, 1);

        // single-cycle pulses every 5 clocks
        strobes.delete();
        wave(5, 1, 6);
        chk("t6_period", strobes[$].p, 5);
        chk("t6_high", strobes[$].h, 1);
        chk("t6_lock", strobes[$].l, 1);

        // randomized trains, occasional long gaps, enable drops and resets
        for (int it = 0; it < 250; it++) begin
            if ($urandom_range(0, 19) == 0) p = $urandom_range(250, 300);
            else p = $urandom_range(2, 70);
            h = $urandom_range(1, p - 1);
            wave(p, h, $urandom_range(1, 3));
            if ($urandom_range(0, 24) == 0) begin
                enable = 1'b0;
                repeat ($urandom_range(1, 4)) tick();
                enable = 1'b1;
            end
            if ($urandom_range(0, 59) == 0) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
            end
        end
        hold_low(20);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
